// File: rtl/buf_exchange_hub.sv
// Shared slot table + inter-core barrier for the per-core buffer-publish interface; reads are zero-latency.
// Release registered 1 cycle after last capture; cores are held by all_buf_flags (no valid/ready stalls).
// Optional watchdog forced release: define BUF_HUB_TIMEOUT_EN.
module buf_exchange_hub #(
    parameter int CORES          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [32*CORES-1:0]   core_val_1,
    input  logic [32*CORES-1:0]   core_val_2,
    input  logic [CORES-1:0]      core_flag,
    input  logic [5*CORES-1:0]    core_addr_1,
    input  logic [5*CORES-1:0]    core_addr_2,
    output logic [32*CORES-1:0]   core_select_1,
    output logic [32*CORES-1:0]   core_select_2,
    output logic                  all_buf_flags,
    output logic                  timeout_flag
);

    localparam int SLOTS = 2 * CORES;

    typedef enum logic {COLLECT, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [CORES-1:0] valid_q, valid_d;
    logic [CORES-1:0] ack_q, ack_d;
    logic [CORES-1:0] cap;
    logic [31:0]      collect_q   [SLOTS];
    logic [31:0]      collect_d   [SLOTS];
    logic [31:0]      published_q [SLOTS];
    logic [31:0]      published_d [SLOTS];
    logic             flags_q, flags_d;
    logic             tmo_hit;
    logic             forced;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        ack_d       = ack_q;
        collect_d   = collect_q;
        published_d = published_q;
        flags_d     = flags_q;
        cap         = '0;
        forced      = 1'b0;
        case (state_q)
            COLLECT: begin
                cap     = core_flag & ~valid_q;
                valid_d = valid_q | cap;
                for (int c = 0; c < CORES; c++) begin
                    if (cap[c]) begin
                        collect_d[2*c]   = core_val_1[32*c +: 32];
                        collect_d[2*c+1] = core_val_2[32*c +: 32];
                    end
                end
                forced = tmo_hit && !(|cap) && !(&valid_d);
                if ((&valid_d) || forced) begin
                    // Publish the merged view so a capture on this same edge is included.
                    for (int c = 0; c < CORES; c++) begin
                        published_d[2*c]   = valid_d[c] ? collect_d[2*c]   : 32'h0;
                        published_d[2*c+1] = valid_d[c] ? collect_d[2*c+1] : 32'h0;
                    end
                    valid_d = '0;
                    ack_d   = '0;
                    flags_d = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                ack_d = ack_q | ~core_flag;
                if (&ack_d) begin
                    ack_d   = '0;
                    flags_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= COLLECT;
            valid_q <= '0;
            ack_q   <= '0;
            flags_q <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                collect_q[s]   <= 32'h0;
                published_q[s] <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ack_q       <= ack_d;
            flags_q     <= flags_d;
            collect_q   <= collect_d;
            published_q <= published_d;
        end
    end

`ifdef BUF_HUB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] tmo_cnt_q;
    logic          tmo_flag_q;

    assign tmo_hit      = (state_q == COLLECT) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES));
    assign timeout_flag = tmo_flag_q;

    // Held at zero outside COLLECT so it restarts from 0 on entry.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            if (state_q != COLLECT || (|cap)) begin
                tmo_cnt_q <= '0;
            end else if (!tmo_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (forced) begin
                tmo_flag_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign all_buf_flags = flags_q;

    // Address decode by compare so out-of-range addresses fall through to 0.
    always_comb begin
        core_select_1 = '0;
        core_select_2 = '0;
        for (int c = 0; c < CORES; c++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (core_addr_1[5*c +: 5] == 5'(s)) begin
                    core_select_1[32*c +: 32] = published_q[s];
                end
                if (core_addr_2[5*c +: 5] == 5'(s)) begin
                    core_select_2[32*c +: 32] = published_q[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_buf_exchange_hub.sv
// Directed bench for buf_exchange_hub with CORES=4, TIMEOUT_CYCLES=16.
module tb_buf_exchange_hub;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [127:0] core_val_1, core_val_2;
    logic [3:0]   core_flag;
    logic [19:0]  core_addr_1, core_addr_2;
    logic [127:0] core_select_1, core_select_2;
    logic         all_buf_flags, timeout_flag;

    int n_cmp = 0;
    int n_bad = 0;

    buf_exchange_hub #(.CORES(4), .TIMEOUT_CYCLES(16)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .core_val_1    (core_val_1),
        .core_val_2    (core_val_2),
        .core_flag     (core_flag),
        .core_addr_1   (core_addr_1),
        .core_addr_2   (core_addr_2),
        .core_select_1 (core_select_1),
        .core_select_2 (core_select_2),
        .all_buf_flags (all_buf_flags),
        .timeout_flag  (timeout_flag)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_core(input int c, input logic [31:0] v1, input logic [31:0] v2);
        core_val_1[32*c +: 32] = v1;
        core_val_2[32*c +: 32] = v2;
        core_flag[c]           = 1'b1;
    endtask

    task automatic set_addr(input int c, input logic [4:0] a1, input logic [4:0] a2);
        core_addr_1[5*c +: 5] = a1;
        core_addr_2[5*c +: 5] = a2;
        #1;
    endtask

    function automatic logic [31:0] sel1(input int c);
        return core_select_1[32*c +: 32];
    endfunction

    function automatic logic [31:0] sel2(input int c);
        return core_select_2[32*c +: 32];
    endfunction

    task automatic test_reset;
        Reset       = 1'b0;
        core_val_1  = '0;
        core_val_2  = '0;
        core_flag   = '0;
        core_addr_1 = {5'd6, 5'd4, 5'd2, 5'd0};
        core_addr_2 = {5'd7, 5'd5, 5'd3, 5'd1};
        #3;
        n_cmp++; if (all_buf_flags !== 1'b0) begin n_bad++; $display("FAIL rst_flags got %0b want 0", all_buf_flags); end
        n_cmp++; if (timeout_flag !== 1'b0) begin n_bad++; $display("FAIL rst_timeout got %0b want 0", timeout_flag); end
        n_cmp++; if (core_select_1 !== 128'h0) begin n_bad++; $display("FAIL rst_sel1 got %h want 0", core_select_1); end
        n_cmp++; if (core_select_2 !== 128'h0) begin n_bad++; $display("FAIL rst_sel2 got %h want 0", core_select_2); end
        tick;
        tick;
        Reset = 1'b1;
        tick;
        n_cmp++; if (all_buf_flags !== 1'b0) begin n_bad++; $display("FAIL post_rst_flags got %0b want 0", all_buf_flags); end
    endtask

    // Flags in cycles 0,3,3,7; core 1 alters val_1 mid-COLLECT; release seen in cycle 8.
    task automatic test_epoch;
        for (int k = 0; k <= 8; k++) begin
            n_cmp++;
            if (all_buf_flags !== (k == 8)) begin
                n_bad++; $display("FAIL epoch_flags cyc%0d got %0b want %0b", k, all_buf_flags, (k == 8));
            end
            if (k == 0) set_core(0, 32'h10, 32'h20);
            if (k == 3) begin set_core(1, 32'h11, 32'h21); set_core(2, 32'h12, 32'h22); end
            if (k == 5) core_val_1[63:32] = 32'hDEAD;
            if (k == 7) begin
                set_core(3, 32'h13, 32'h23);
                set_addr(0, 5'd5, 5'd7);
                n_cmp++; if (sel1(0) !== 32'h0) begin n_bad++; $display("FAIL copy_edge_old got %h want 0", sel1(0)); end
            end
            if (k < 8) tick;
        end
        n_cmp++; if (sel1(0) !== 32'h22) begin n_bad++; $display("FAIL read_slot5 got %h want 22", sel1(0)); end
        n_cmp++; if (sel2(0) !== 32'h23) begin n_bad++; $display("FAIL read_slot7 got %h want 23", sel2(0)); end
        n_cmp++; if (sel1(1) !== 32'h11) begin n_bad++; $display("FAIL first_capture got %h want 11", sel1(1)); end
        n_cmp++; if (sel2(1) !== 32'h21) begin n_bad++; $display("FAIL read_slot3 got %h want 21", sel2(1)); end
    endtask

    // Now in cycle 8 (RELEASE). Drops at 10,11,12; core 0 re-raises at 11 with 0x55.
    task automatic test_release;
        tick;
        tick;
        n_cmp++; if (all_buf_flags !== 1'b1) begin n_bad++; $display("FAIL rel_c10 got %0b want 1", all_buf_flags); end
        core_flag[0] = 1'b0;
        core_flag[1] = 1'b0;
        tick;
        n_cmp++; if (all_buf_flags !== 1'b1) begin n_bad++; $display("FAIL rel_c11 got %0b want 1", all_buf_flags); end
        core_flag[2] = 1'b0;
        set_core(0, 32'h55, 32'h20);
        tick;
        n_cmp++; if (all_buf_flags !== 1'b1) begin n_bad++; $display("FAIL rel_c12 got %0b want 1", all_buf_flags); end
        core_flag[3] = 1'b0;
        tick;
        n_cmp++; if (all_buf_flags !== 1'b0) begin n_bad++; $display("FAIL rel_c13 got %0b want 0", all_buf_flags); end
        n_cmp++; if (sel1(0) !== 32'h22) begin n_bad++; $display("FAIL epoch_stable got %h want 22", sel1(0)); end
        for (int c = 1; c < 4; c++) set_core(c, 32'h30 + c, 32'h40 + c);
        tick;
        n_cmp++; if (all_buf_flags !== 1'b1) begin n_bad++; $display("FAIL epoch2_flags got %0b want 1", all_buf_flags); end
        set_addr(0, 5'd0, 5'd1);
        n_cmp++; if (sel1(0) !== 32'h55) begin n_bad++; $display("FAIL reraise_capture got %h want 55", sel1(0)); end
        n_cmp++; if (sel2(0) !== 32'h20) begin n_bad++; $display("FAIL slot1 got %h want 20", sel2(0)); end
        n_cmp++; if (sel1(1) !== 32'h31) begin n_bad++; $display("FAIL slot2_new got %h want 31", sel1(1)); end
    endtask

    task automatic test_addr_range;
        set_addr(2, 5'd8, 5'd31);
        n_cmp++; if (sel1(2) !== 32'h0) begin n_bad++; $display("FAIL addr8 got %h want 0", sel1(2)); end
        n_cmp++; if (sel2(2) !== 32'h0) begin n_bad++; $display("FAIL addr31 got %h want 0", sel2(2)); end
        set_addr(3, 5'd7, 5'd6);
        n_cmp++; if (sel1(3) !== 32'h43) begin n_bad++; $display("FAIL addr7 got %h want 43", sel1(3)); end
        n_cmp++; if (sel2(3) !== 32'h33) begin n_bad++; $display("FAIL addr6 got %h want 33", sel2(3)); end
        core_flag = '0;
        tick;
        n_cmp++; if (all_buf_flags !== 1'b0) begin n_bad++; $display("FAIL back_to_collect got %0b want 0", all_buf_flags); end
    endtask

    task automatic test_reset_mid;
        set_core(0, 32'h60, 32'h70);
        set_core(1, 32'h61, 32'h71);
        tick;
        Reset = 1'b0;
        #1;
        n_cmp++; if (sel1(3) !== 32'h0) begin n_bad++; $display("FAIL midrst_read got %h want 0", sel1(3)); end
        n_cmp++; if (all_buf_flags !== 1'b0) begin n_bad++; $display("FAIL midrst_flags got %0b want 0", all_buf_flags); end
        tick;
        Reset = 1'b1;
        set_core(2, 32'h62, 32'h72);
        for (int k = 0; k < 4; k++) begin
            tick;
            n_cmp++; if (all_buf_flags !== 1'b0) begin n_bad++; $display("FAIL midrst_wait%0d got %0b want 0", k, all_buf_flags); end
        end
        set_core(3, 32'h73, 32'h83);
        tick;
        n_cmp++; if (all_buf_flags !== 1'b1) begin n_bad++; $display("FAIL midrst_release got %0b want 1", all_buf_flags); end
        n_cmp++; if (sel1(3) !== 32'h83) begin n_bad++; $display("FAIL midrst_slot7 got %h want 83", sel1(3)); end
        core_flag = '0;
        tick;
    endtask

    task automatic test_timeout;
`ifdef BUF_HUB_TIMEOUT_EN
        Reset = 1'b0;
        #1;
        tick;
        Reset = 1'b1;
        for (int c = 0; c < 3; c++) set_core(c, 32'h90 + c, 32'hA0 + c);
        tick;
        for (int k = 1; k <= 17; k++) begin
            n_cmp++; if (all_buf_flags !== 1'b0) begin n_bad++; $display("FAIL tmo_wait cyc%0d got %0b want 0", k, all_buf_flags); end
            tick;
        end
        n_cmp++; if (all_buf_flags !== 1'b1) begin n_bad++; $display("FAIL tmo_release got %0b want 1", all_buf_flags); end
        n_cmp++; if (timeout_flag !== 1'b1) begin n_bad++; $display("FAIL tmo_flag got %0b want 1", timeout_flag); end
        set_addr(0, 5'd6, 5'd7);
        n_cmp++; if (sel1(0) !== 32'h0) begin n_bad++; $display("FAIL tmo_slot6 got %h want 0", sel1(0)); end
        n_cmp++; if (sel2(0) !== 32'h0) begin n_bad++; $display("FAIL tmo_slot7 got %h want 0", sel2(0)); end
        set_addr(1, 5'd4, 5'd5);
        n_cmp++; if (sel1(1) !== 32'h92) begin n_bad++; $display("FAIL tmo_slot4 got %h want 92", sel1(1)); end
        core_flag = '0;
        tick;
        tick;
        n_cmp++; if (all_buf_flags !== 1'b0) begin n_bad++; $display("FAIL tmo_back got %0b want 0", all_buf_flags); end
        n_cmp++; if (timeout_flag !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky got %0b want 1", timeout_flag); end
        Reset = 1'b0;
        #1;
        n_cmp++; if (timeout_flag !== 1'b0) begin n_bad++; $display("FAIL tmo_rst got %0b want 0", timeout_flag); end
        tick;
        Reset = 1'b1;
`else
        n_cmp++; if (timeout_flag !== 1'b0) begin n_bad++; $display("FAIL tmo_tied got %0b want 0", timeout_flag); end
`endif
    endtask

    initial begin
        test_reset;
        test_epoch;
        test_release;
        test_addr_range;
        test_reset_mid;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
